// File: rtl/ad9866_cmd_sched_if.sv
// ad9866_cmd_sched_if
//   Groups the host register port and the SPI engine handshake of the
//   AD9866 command scheduler.
//   modport slave  : the scheduler (receives host requests, drives the engine)
//   modport master : the environment (host requester plus serial engine)
//   Host port  : host_valid/host_ready request handshake, host_rw, host_addr,
//                host_wdata, host_rdata/host_rdata_valid read return.
//   Engine port: spi_start/spi_word request, spi_busy/spi_done/spi_rdata status.
interface ad9866_cmd_sched_if;
    logic        host_valid;
    logic        host_ready;
    logic        host_rw;
    logic [4:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_rdata_valid;
    logic        spi_start;
    logic [15:0] spi_word;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rdata;

    modport slave (
        input  host_valid, host_rw, host_addr, host_wdata,
        input  spi_busy, spi_done, spi_rdata,
        output host_ready, host_rdata, host_rdata_valid,
        output spi_start, spi_word
    );

    modport master (
        output host_valid, host_rw, host_addr, host_wdata,
        output spi_busy, spi_done, spi_rdata,
        input  host_ready, host_rdata, host_rdata_valid,
        input  spi_start, spi_word
    );
endinterface

// File: rtl/ad9866_cmd_sched.sv
// ad9866_cmd_sched
//   Schedules run-time SPI register traffic (RX gain reg 0x09, TX gain reg
//   0x0A, host register port) to the AD9866 serial engine once its power-up
//   init sequence is done. Round-robin arbitration over host -> tx -> rx,
//   gain changes coalesced (value latched at grant), watchdog on stuck
//   transfers, minimum idle gap between engine transfers.
//
//   Handshakes:
//     host : host_valid is held until host_ready; host_ready is a one-cycle
//            pulse meaning the request fields have been captured.
//     spi  : spi_start is held with a stable spi_word until spi_busy is seen;
//            spi_done is a one-cycle pulse ending the transfer, spi_rdata is
//            valid with it.
//
//   Ports: clk, reset (async, active-high), init_done, rx_gain, tx_gain,
//          clr_err, grant (0 host, 1 tx, 2 rx), timeout_err (sticky),
//          dbg_state_o (FSM state), bus (ad9866_cmd_sched_if.slave).
//
//   Build option: define AD9866_READBACK_EN to support host reads
//   (spi_word bit15 = host_rw, read data returned on host_rdata).
//   Without it every host request is a write and the read return is tied 0.
module ad9866_cmd_sched #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_done,
    input  logic [5:0]               rx_gain,
    input  logic [5:0]               tx_gain,
    input  logic                     clr_err,
    output logic [1:0]               grant,
    output logic                     timeout_err,
    output logic [2:0]               dbg_state_o,
    ad9866_cmd_sched_if.slave        bus
);

    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    localparam logic [1:0] G_HOST = 2'd0;
    localparam logic [1:0] G_TX   = 2'd1;
    localparam logic [1:0] G_RX   = 2'd2;

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_BUSY      = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t           state_q;
    logic [1:0]       rr_q;
    logic [1:0]       grant_q;
    logic [15:0]      word_q;
    logic             start_q;
    logic             host_ready_q;
    logic             host_read_q;
    logic [7:0]       rdata_q;
    logic             rdv_q;
    logic             terr_q;
    logic [5:0]       last_rx_q;
    logic [5:0]       last_tx_q;
    logic             ok_rx_q;
    logic             ok_tx_q;
    logic [WD_W-1:0]  wd_q;
    logic [GAP_W-1:0] gap_q;

    logic             eff_rw;

`ifdef AD9866_READBACK_EN
    assign eff_rw                = bus.host_rw;
    assign bus.host_rdata        = rdata_q;
    assign bus.host_rdata_valid  = rdv_q;
`else
    logic unused_readback;
    assign eff_rw                = 1'b0;
    assign bus.host_rdata        = 8'h00;
    assign bus.host_rdata_valid  = 1'b0;
    assign unused_readback       = ^{bus.host_rw, rdata_q, rdv_q};
`endif

    // Pending vector indexed by grant code; bit 3 is a never-pending pad.
    logic [3:0] pend;
    assign pend = {1'b0,
                   (!ok_rx_q || (rx_gain != last_rx_q)),
                   (!ok_tx_q || (tx_gain != last_tx_q)),
                   bus.host_valid};

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g == G_RX) ? G_HOST : g + 2'd1;
    endfunction

    // First pending requester strictly after the last grant, wrapping.
    logic [1:0]  c1, c2, c3, sel_d;
    logic [15:0] word_d;
    always_comb begin
        c1    = rr_next(rr_q);
        c2    = rr_next(c1);
        c3    = rr_next(c2);
        sel_d = c3;
        if (pend[c1])      sel_d = c1;
        else if (pend[c2]) sel_d = c2;

        word_d = {eff_rw, 2'b00, bus.host_addr, eff_rw ? 8'h00 : bus.host_wdata};
        if (sel_d == G_TX) word_d = {1'b0, 2'b00, 5'h0A, 2'b01, tx_gain};
        if (sel_d == G_RX) word_d = {1'b0, 2'b00, 5'h09, 2'b01, rx_gain};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_WAIT_INIT;
            rr_q         <= G_RX;
            grant_q      <= G_HOST;
            word_q       <= '0;
            start_q      <= 1'b0;
            host_ready_q <= 1'b0;
            host_read_q  <= 1'b0;
            rdata_q      <= '0;
            rdv_q        <= 1'b0;
            terr_q       <= 1'b0;
            last_rx_q    <= '0;
            last_tx_q    <= '0;
            ok_rx_q      <= 1'b0;
            ok_tx_q      <= 1'b0;
            wd_q         <= '0;
            gap_q        <= '0;
        end else begin
            host_ready_q <= 1'b0;
            rdv_q        <= 1'b0;
            case (state_q)
                S_WAIT_INIT: begin
                    if (init_done) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (!init_done) begin
                        state_q <= S_WAIT_INIT;
                    end else if (|pend) begin
                        grant_q      <= sel_d;
                        word_q       <= word_d;
                        start_q      <= 1'b1;
                        wd_q         <= '0;
                        host_ready_q <= (sel_d == G_HOST);
                        host_read_q  <= (sel_d == G_HOST) && eff_rw;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_BUSY: begin
                    // Done beats a same-cycle watchdog expiry.
                    if (bus.spi_done) begin
                        start_q <= 1'b0;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                        if (grant_q == G_RX) begin
                            last_rx_q <= word_q[5:0];
                            ok_rx_q   <= 1'b1;
                        end
                        if (grant_q == G_TX) begin
                            last_tx_q <= word_q[5:0];
                            ok_tx_q   <= 1'b1;
                        end
                        if (host_read_q) begin
                            rdata_q <= bus.spi_rdata;
                            rdv_q   <= 1'b1;
                        end
                    end else if (wd_q == WD_LAST) begin
                        // Gain bookkeeping untouched so the requester retries.
                        terr_q  <= 1'b1;
                        start_q <= 1'b0;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                        if (host_read_q) begin
                            rdata_q <= 8'hFF;
                            rdv_q   <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                        if (state_q == S_ISSUE && bus.spi_busy) begin
                            start_q <= 1'b0;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        rr_q    <= grant_q;
                        state_q <= init_done ? S_IDLE : S_WAIT_INIT;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_WAIT_INIT;
            endcase
            // Clear has priority over a same-cycle watchdog set.
            if (clr_err) terr_q <= 1'b0;
        end
    end

    assign grant          = grant_q;
    assign timeout_err    = terr_q;
    assign dbg_state_o    = state_q;
    assign bus.host_ready = host_ready_q;
    assign bus.spi_start  = start_q;
    assign bus.spi_word   = word_q;

endmodule
